// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: primary opcodes and the forwarding-tracker
// entry layout used by the hazard logic.
package mips_pkg;

  // Widest register address any instance may use; narrower REG_AW values are
  // zero-extended into fwd_entry_t.dst.
  localparam int unsigned MAX_REG_AW = 8;

  typedef enum logic [5:0] {
    OP_RT   = 6'h00,
    OP_J    = 6'h02,
    OP_JAL  = 6'h03,
    OP_BEQ  = 6'h04,
    OP_ADDI = 6'h08,
    OP_SLTI = 6'h0A,
    OP_LW   = 6'h23,
    OP_SW   = 6'h2B
  } opcode_t;

  // JR is an R-type instruction selected by its funct field.
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef struct packed {
    logic                  wr;
    logic                  ld;
    logic [MAX_REG_AW-1:0] dst;
  } fwd_entry_t;

  localparam fwd_entry_t FWD_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage decoded fields into the hazard unit, forwarding selects and stall out.
interface fwd_hazard_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned STAGES = 2
);
  localparam int unsigned FWD_W = $clog2(STAGES + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_writes;
  logic              id_is_load;
  logic [REG_AW-1:0] id_dst;
  logic              flush;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;
  logic              stall;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_writes, id_is_load, id_dst, flush,
    input  fwd_a, fwd_b, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_writes, id_is_load, id_dst, flush,
    output fwd_a, fwd_b, stall
  );

endinterface

// File: rtl/fwd_prio_sel.sv
// Priority encoder over tracker hits: lowest (youngest) hitting entry wins.
module fwd_prio_sel #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned FWD_W  = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [STAGES-1:0] hit,
  output logic [FWD_W-1:0]  sel,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    sel = '0;
    idx = '0;
    any = |hit;
    // Walk oldest to youngest so the youngest hit overwrites last.
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (hit[STAGES-1-k]) begin
        sel = FWD_W'(STAGES - k);
        idx = IDX_W'(STAGES - 1 - k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks the last STAGES destinations and
// drives operand forwarding selects plus a load-use stall for the ID stage.
module fwd_hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned STAGES   = 2,
  parameter int          LOAD_LAT = 1,
  parameter bit          ZERO_HW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  fwd_hazard_unit_if.slave       hz
);

  localparam int unsigned FWD_W = $clog2(STAGES + 1);
  localparam int unsigned IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  fwd_entry_t        ent [STAGES];
  logic [STAGES-1:0] hit_a, hit_b;
  logic [FWD_W-1:0]  sel_a, sel_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic              any_a, any_b;
  logic              ld_a, ld_b;
  logic              stall;
  logic              rs_ok, rt_ok;

  assign rs_ok = hz.id_valid && hz.id_uses_rs && !(ZERO_HW && hz.id_rs == '0);
  assign rt_ok = hz.id_valid && hz.id_uses_rt && !(ZERO_HW && hz.id_rt == '0);

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      hit_a[k] = rs_ok && ent[k].wr && (ent[k].dst == MAX_REG_AW'(hz.id_rs));
      hit_b[k] = rt_ok && ent[k].wr && (ent[k].dst == MAX_REG_AW'(hz.id_rt));
    end
  end

  fwd_prio_sel #(.STAGES(STAGES), .FWD_W(FWD_W), .IDX_W(IDX_W)) u_sel_a (
    .hit (hit_a),
    .sel (sel_a),
    .idx (idx_a),
    .any (any_a)
  );

  fwd_prio_sel #(.STAGES(STAGES), .FWD_W(FWD_W), .IDX_W(IDX_W)) u_sel_b (
    .hit (hit_b),
    .sel (sel_b),
    .idx (idx_b),
    .any (any_b)
  );

  // Only the winning producer matters: a younger non-load writer shadows a load.
  assign ld_a  = any_a && (int'(idx_a) < LOAD_LAT) && ent[idx_a].ld;
  assign ld_b  = any_b && (int'(idx_b) < LOAD_LAT) && ent[idx_b].ld;
  assign stall = ld_a || ld_b;

  assign hz.stall = stall;
  assign hz.fwd_a = stall ? '0 : sel_a;
  assign hz.fwd_b = stall ? '0 : sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) ent[k] <= FWD_BUBBLE;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) ent[k] <= ent[k-1];
      if (stall || hz.flush) begin
        ent[0] <= FWD_BUBBLE;
      end else begin
        ent[0].wr  <= hz.id_writes && hz.id_valid;
        ent[0].ld  <= hz.id_is_load && hz.id_valid;
        ent[0].dst <= MAX_REG_AW'(hz.id_dst);
      end
    end
  end

endmodule
